// File: rtl/cmp_filter_seq.sv
// cmp_filter_seq -- sequencer for the complementary attitude filter.
//
// Decimates IMU sample-ready pulses, fires a single-cycle enable strobe into
// the filter, then holds a valid/ready attitude handshake towards the PID
// stage. Samples arriving while a filter transaction is in flight are
// dropped and counted in a saturating overrun counter.
//
// Optional feature macro: CMP_SEQ_WDOG_EN
//   defined   -> no-sample watchdog in WAIT; expiry enters a sticky FAULT
//                state that is left only by dropping start.
//   undefined -> no watchdog logic, imu_fault tied low, TIMEOUT_CYC unused.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   level: 1 = run the loop, 0 = stop / clear fault
//   imu_valid  in   one-cycle pulse, new angles stable on filter inputs
//   imu_ready  out  sequencer can accept a sample (WAIT)
//   filt_en    out  one-cycle enable strobe to the filter (FILTER)
//   att_valid  out  filter outputs hold a fresh attitude (PRESENT)
//   att_ready  in   PID consumed the attitude
//   busy       out  state is FILTER or PRESENT
//   imu_fault  out  sticky watchdog fault
//   ovr_cnt    out  saturating count of dropped samples
module cmp_filter_seq #(
    parameter int unsigned DIV         = 1,
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned OVR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imu_valid,
    output logic             imu_ready,
    output logic             filt_en,
    output logic             att_valid,
    input  logic             att_ready,
    output logic             busy,
    output logic             imu_fault,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_FILTER  = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [7:0]       DEC_LAST = 8'(DIV - 1);
    localparam logic [OVR_W-1:0] OVR_MAX  = '1;

    logic [2:0]       state_q, state_d;
    logic [7:0]       dec_q, dec_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             imu_ready_q, filt_en_q, att_valid_q, busy_q;
    logic             wd_clr, wd_inc, wd_expired;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        ovr_d   = ovr_q;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;

        // A sample landing outside IDLE/WAIT cannot be used: drop and count it.
        if (imu_valid && (state_q != S_IDLE) && (state_q != S_WAIT) && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    dec_d   = '0;
                    wd_clr  = 1'b1;
                end
            end
            S_WAIT: begin
                if (imu_valid) begin
                    // An accepted sample always finishes its bookkeeping, even
                    // when start drops on the same edge.
                    wd_clr = 1'b1;
                    if (dec_q == DEC_LAST) begin
                        dec_d   = '0;
                        state_d = S_FILTER;
                    end else begin
                        dec_d = dec_q + 8'd1;
                        if (!start) begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (!start) begin
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_FILTER: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (att_ready) begin
                    state_d = start ? S_WAIT : S_IDLE;
                end
            end
            S_FAULT: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dec_q       <= '0;
            ovr_q       <= '0;
            imu_ready_q <= 1'b0;
            filt_en_q   <= 1'b0;
            att_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            ovr_q       <= ovr_d;
            imu_ready_q <= (state_d == S_WAIT);
            filt_en_q   <= (state_d == S_FILTER);
            att_valid_q <= (state_d == S_PRESENT);
            busy_q      <= (state_d == S_FILTER) || (state_d == S_PRESENT);
        end
    end

`ifdef CMP_SEQ_WDOG_EN
    localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            fault_q;

    // The counter only advances while waiting; the sample that starts a
    // transaction clears it, so it restarts from zero on the return to WAIT.
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q;
        if (wd_clr) begin
            wd_d = '0;
        end else if (wd_inc) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign imu_fault = fault_q;
`else
    logic unused_wdog;

    assign wd_expired  = 1'b0;
    assign unused_wdog = (TIMEOUT_CYC == 0) | wd_clr | wd_inc;
    assign imu_fault   = 1'b0;
`endif

    assign imu_ready = imu_ready_q;
    assign filt_en   = filt_en_q;
    assign att_valid = att_valid_q;
    assign busy      = busy_q;
    assign ovr_cnt   = ovr_q;

endmodule
